// File: rtl/write_back_buffer.sv
// Word-granular write-back FIFO between cache eviction port and DataMemory, with read forwarding.
// Latency: accepted push visible to lookup/drain next cycle; forwarding and drain decision are combinational.
// Backpressure: wb_ready_o drops only when full; a full buffer forces a drain write and withholds the read grant.
module write_back_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_valid_i,
    input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    output logic                    wb_ready_o,
    input  logic                    mem_rd_req_i,
    output logic                    rd_grant_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
    output logic                    fwd_hit_o,
    output logic [DATA_WIDTH-1:0]   fwd_data_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  addr_d [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q [DEPTH];
    logic [DATA_WIDTH-1:0]  data_d [DEPTH];
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;

    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          co_hit;
    logic [PW-1:0] co_idx;
    logic          append;
    logic          coalesce;

    // Byte-offset bits of the lookup address never take part in the word compare.
    logic unused_lookup_lo;
    assign unused_lookup_lo = ^lookup_addr_i[1:0];

    // Occupancy status, drain arbitration and the memory write port driven from the head entry.
    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        pop         = !empty && (full || !mem_rd_req_i);
        push        = wb_valid_i && !full;
        wb_ready_o  = !full;
        rd_grant_o  = !full;
        mem_we_o    = pop;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!empty) begin
            mem_addr_o  = addr_q[head_q];
            mem_wdata_o = data_q[head_q];
        end
    end

    // Find a live entry for the pushed word; the head leaving this cycle cannot absorb it.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_WIDTH-1:2] == wb_addr_i[ADDR_WIDTH-1:2])
                && !(pop && (PW'(i) == head_q))) begin
                co_hit = 1'b1;
                co_idx = PW'(i);
            end
        end
        append   = push && !co_hit;
        coalesce = push && co_hit;
    end

    // Forward buffered data to the read lookup; the head being popped still counts as buffered.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_WIDTH-1:2] == lookup_addr_i[ADDR_WIDTH-1:2])) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[i];
            end
        end
    end

    // Next-state: pop at head, append at tail or overwrite in place, and track occupancy.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (append) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = wb_addr_i;
            data_d[tail_q]  = wb_data_i;
            tail_d          = tail_q + PW'(1);
        end
        if (coalesce) begin
            data_d[co_idx] = wb_data_i;
        end
        case ({append, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_write_back_buffer.sv
// Bench for write_back_buffer: directed pushes, memory writes checked by a scoreboard monitor.
module tb_write_back_buffer;

    logic        clk;
    logic        rst_n;
    logic        wb_valid_i;
    logic [31:0] wb_addr_i;
    logic [31:0] wb_data_i;
    logic        wb_ready_o;
    logic        mem_rd_req_i;
    logic        rd_grant_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] lookup_addr_i;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    write_back_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid_i    (wb_valid_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .wb_ready_o    (wb_ready_o),
        .mem_rd_req_i  (mem_rd_req_i),
        .rd_grant_o    (rd_grant_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .lookup_addr_i (lookup_addr_i),
        .fwd_hit_o     (fwd_hit_o),
        .fwd_data_o    (fwd_data_o),
        .count_o       (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory-side monitor: every write strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (rst_n && mem_we_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_write_unexpected: got %0h/%0h expected none", mem_addr_o, mem_wdata_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({mem_addr_o, mem_wdata_o} !== e) begin
                    errors++;
                    $display("FAIL mem_write: got %0h/%0h expected %0h/%0h",
                             mem_addr_o, mem_wdata_o, e[63:32], e[31:0]);
                end
            end
        end
    end

    // One accepted push; called and returns at 1 time unit after a rising edge.
    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wb_valid_i = 1'b1;
        wb_addr_i  = a;
        wb_data_i  = d;
        chk("push_ready", {63'd0, wb_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (count_o != 3'd0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, {61'd0, count_o}, 64'd0);
    endtask

    initial begin
        int maxc;
        rst_n         = 1'b1;
        wb_valid_i    = 1'b0;
        wb_addr_i     = '0;
        wb_data_i     = '0;
        mem_rd_req_i  = 1'b0;
        lookup_addr_i = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_count",  {61'd0, count_o},    64'd0);
        chk("reset_ready",  {63'd0, wb_ready_o}, 64'd1);
        chk("reset_grant",  {63'd0, rd_grant_o}, 64'd1);
        chk("reset_we",     {63'd0, mem_we_o},   64'd0);
        chk("reset_fwd",    {63'd0, fwd_hit_o},  64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full under a pending read: write is forced, read grant withheld.
        mem_rd_req_i = 1'b1;
        exp_q.push_back({32'h100, 32'hA});
        exp_q.push_back({32'h104, 32'hB});
        exp_q.push_back({32'h108, 32'hC});
        exp_q.push_back({32'h10C, 32'hD});
        push(32'h100, 32'hA);
        push(32'h104, 32'hB);
        push(32'h108, 32'hC);
        push(32'h10C, 32'hD);
        chk("full_count", {61'd0, count_o},    64'd4);
        chk("full_ready", {63'd0, wb_ready_o}, 64'd0);
        chk("full_grant", {63'd0, rd_grant_o}, 64'd0);
        chk("full_we",    {63'd0, mem_we_o},   64'd1);
        chk("full_addr",  {32'd0, mem_addr_o}, 64'h100);
        chk("full_data",  {32'd0, mem_wdata_o}, 64'hA);
        mem_rd_req_i = 1'b0;
        wait_empty("fill_drained");

        // Coalesce: second push to the same word overwrites in place.
        mem_rd_req_i  = 1'b1;
        lookup_addr_i = 32'h200;
        wb_valid_i    = 1'b1;
        wb_addr_i     = 32'h200;
        wb_data_i     = 32'h11;
        #1;
        chk("same_cycle_push_not_fwd", {63'd0, fwd_hit_o}, 64'd0);
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0;
        push(32'h200, 32'h22);
        chk("coalesce_count", {61'd0, count_o}, 64'd1);
        lookup_addr_i = 32'h202;
        #1;
        chk("coalesce_hit",  {63'd0, fwd_hit_o},  64'd1);
        chk("coalesce_data", {32'd0, fwd_data_o}, 64'h22);
        lookup_addr_i = 32'h204;
        #1;
        chk("miss_hit",  {63'd0, fwd_hit_o},  64'd0);
        chk("miss_data", {32'd0, fwd_data_o}, 64'd0);
        exp_q.push_back({32'h200, 32'h22});
        mem_rd_req_i = 1'b0;
        wait_empty("coalesce_drained");

        // Push matching the head being popped appends a second entry.
        mem_rd_req_i = 1'b1;
        push(32'h300, 32'h1);
        exp_q.push_back({32'h300, 32'h1});
        exp_q.push_back({32'h300, 32'h2});
        mem_rd_req_i = 1'b0;
        push(32'h300, 32'h2);
        chk("popmatch_count", {61'd0, count_o},     64'd1);
        chk("popmatch_data",  {32'd0, mem_wdata_o}, 64'h2);
        wait_empty("popmatch_drained");

        // Ten back-to-back pushes with free drain: pointers wrap, occupancy stays at one.
        maxc = 0;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back({32'h400 + 32'(k * 4), 32'h1000 + 32'(k)});
            push(32'h400 + 32'(k * 4), 32'h1000 + 32'(k));
            if (int'(count_o) > maxc) maxc = int'(count_o);
        end
        wait_empty("wrap_drained");
        chk("wrap_max_count", 64'(maxc), 64'd1);

        // Read priority holds off draining while not full.
        mem_rd_req_i = 1'b1;
        exp_q.push_back({32'h500, 32'h55});
        exp_q.push_back({32'h504, 32'h66});
        push(32'h500, 32'h55);
        push(32'h504, 32'h66);
        for (int i = 0; i < 5; i++) begin
            chk("prio_we",    {63'd0, mem_we_o},   64'd0);
            chk("prio_grant", {63'd0, rd_grant_o}, 64'd1);
            @(posedge clk);
            #1;
        end
        mem_rd_req_i = 1'b0;
        #1;
        chk("prio_resume_we",   {63'd0, mem_we_o},   64'd1);
        chk("prio_resume_addr", {32'd0, mem_addr_o}, 64'h500);
        wait_empty("prio_drained");

        // Asynchronous reset while three entries are buffered and a drain is under way.
        mem_rd_req_i = 1'b1;
        push(32'h600, 32'h1);
        push(32'h604, 32'h2);
        push(32'h608, 32'h3);
        lookup_addr_i = 32'h604;
        mem_rd_req_i  = 1'b0;
        #1;
        chk("pre_reset_we",  {63'd0, mem_we_o},  64'd1);
        chk("pre_reset_hit", {63'd0, fwd_hit_o}, 64'd1);
        chk("pre_reset_count", {61'd0, count_o}, 64'd3);
        rst_n = 1'b0;
        #1;
        chk("midreset_count", {61'd0, count_o},    64'd0);
        chk("midreset_we",    {63'd0, mem_we_o},   64'd0);
        chk("midreset_fwd",   {63'd0, fwd_hit_o},  64'd0);
        chk("midreset_ready", {63'd0, wb_ready_o}, 64'd1);
        chk("midreset_addr",  {32'd0, mem_addr_o}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
